fsyn_ctl: RTL and testbench

Carrier-acquisition sequencer for the fsyn carrier frequency synchroniser.
- Consumes fsyn's per-measurement outputs (avgfrq, fcd, fmv strobe).
- Drives fsyn's mode input (sfs) and noise-floor threshold (nfl).
- Integrates frequency error into a signed NCO offset word that feeds the downconverter NCO.
- Sequences acquisition as IDLE → FAST (coarse) → SLOW (fine track), with HOLD on carrier loss.

---
 rtl/fsyn_ctl.sv | 231 +++++++++++++++++++++++
 tb/tb_fsyn_ctl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/fsyn_ctl.sv
`default_nettype none
// ============================================================================
// Module      : fsyn_ctl
// Description : Carrier-acquisition sequencer for the fsyn carrier frequency
//               synchroniser. Integrates fsyn's averaged frequency error into
//               a saturating signed NCO offset and steps the acquisition
//               through IDLE -> FAST (coarse) -> SLOW (fine track). Carrier
//               loss moves it to HOLD, where the offset is frozen.
// Ports       : clk    - system clock, rising edge
//               rst    - synchronous reset, active-high
//               en     - enable acquisition; 0 forces IDLE and clears fof
//               thr    - noise-floor threshold, captured on IDLE -> FAST
//               fmv    - one-cycle measurement-valid strobe from fsyn
//               avgfrq - signed averaged frequency error from fsyn
//               fcd    - carrier-detect flag, meaningful only with fmv
//               nfl    - latched threshold driven back to fsyn
//               sfs    - fsyn slow-mode select (1 only in SLOW)
//               fof    - signed 24-bit NCO frequency offset
//               upd    - one-cycle pulse on every change of fof
//               lck    - carrier locked (1 only in SLOW)
// Revision    : 1.0 - initial release
// ============================================================================
module fsyn_ctl #(
    parameter int FSH = 2,
    parameter int SSH = 6,
    parameter int LTH = 512,
    parameter int UTH = 2048,
    parameter int LCN = 16,
    parameter int LOS = 8,
    parameter int HTO = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] thr,
    input  logic        fmv,
    input  logic [15:0] avgfrq,
    input  logic        fcd,
    output logic [15:0] nfl,
    output logic        sfs,
    output logic [23:0] fof,
    output logic        upd,
    output logic        lck
);

    localparam int c_LCN_W = $clog2(LCN + 1);
    localparam int c_LOS_W = $clog2(LOS + 1);
    localparam int c_HTO_W = $clog2(HTO + 1);

    localparam logic [c_LCN_W-1:0] c_LCN_V = c_LCN_W'(LCN);
    localparam logic [c_LOS_W-1:0] c_LOS_V = c_LOS_W'(LOS);
    localparam logic [c_HTO_W-1:0] c_HTO_V = c_HTO_W'(HTO);
    localparam logic [16:0]        c_LTH_V = 17'(LTH);
    localparam logic [16:0]        c_UTH_V = 17'(UTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FAST = 2'd1,
        S_SLOW = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nx;
    logic [23:0]          r_fof;
    logic [23:0]          w_fof_nx;
    logic [15:0]          r_nfl;
    logic [15:0]          w_nfl_nx;
    logic                 r_sfs;
    logic                 r_lck;
    logic                 r_upd;
    logic [c_LCN_W-1:0]   r_lcnt;
    logic [c_LCN_W-1:0]   w_lcnt_nx;
    logic [c_LOS_W-1:0]   r_lsc;
    logic [c_LOS_W-1:0]   w_lsc_nx;
    logic [c_HTO_W-1:0]   r_hcnt;
    logic [c_HTO_W-1:0]   w_hcnt_nx;

    // Work in 26 bits so fof minus the largest correction cannot wrap
    // before saturation is applied.
    logic signed [25:0]   w_avg_ext;
    logic signed [25:0]   w_fof_ext;
    logic signed [25:0]   w_sum_f;
    logic signed [25:0]   w_sum_s;
    logic [16:0]          w_avg17;
    logic [16:0]          w_mag;
    logic [c_LCN_W-1:0]   w_lcnt_inc;
    logic [c_LOS_W-1:0]   w_lsc_inc;
    logic [c_HTO_W-1:0]   w_hcnt_inc;

    function automatic logic [23:0] sat24(input logic signed [25:0] v);
        if (v > 26'sd8388607) begin
            return 24'h7F_FFFF;
        end else if (v < -26'sd8388608) begin
            return 24'h80_0000;
        end else begin
            return v[23:0];
        end
    endfunction

    assign w_avg_ext  = {{10{avgfrq[15]}}, avgfrq};
    assign w_fof_ext  = {{2{r_fof[23]}}, r_fof};
    // Arithmetic shift floors toward minus infinity (-5 >>> 2 = -2).
    assign w_sum_f    = w_fof_ext - (w_avg_ext >>> FSH);
    assign w_sum_s    = w_fof_ext - (w_avg_ext >>> SSH);
    // 17-bit magnitude so that |-32768| is representable.
    assign w_avg17    = {avgfrq[15], avgfrq};
    assign w_mag      = avgfrq[15] ? (17'd0 - w_avg17) : w_avg17;
    assign w_lcnt_inc = r_lcnt + c_LCN_W'(1);
    assign w_lsc_inc  = r_lsc + c_LOS_W'(1);
    assign w_hcnt_inc = r_hcnt + c_HTO_W'(1);

    always_comb begin
        w_state_nx = r_state;
        w_fof_nx   = r_fof;
        w_nfl_nx   = r_nfl;
        w_lcnt_nx  = r_lcnt;
        w_lsc_nx   = r_lsc;
        w_hcnt_nx  = r_hcnt;

        if (!en) begin
            // Disable wins over any strobe in the same cycle.
            w_state_nx = S_IDLE;
            w_fof_nx   = '0;
            w_lcnt_nx  = '0;
            w_lsc_nx   = '0;
            w_hcnt_nx  = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nx = S_FAST;
                    w_nfl_nx   = thr;
                    w_fof_nx   = '0;
                    w_lcnt_nx  = '0;
                    w_lsc_nx   = '0;
                    w_hcnt_nx  = '0;
                end
                S_FAST, S_SLOW: begin
                    if (fmv) begin
                        if (fcd) begin
                            w_lsc_nx = '0;
                            if (r_state == S_FAST) begin
                                w_fof_nx = sat24(w_sum_f);
                                if (w_mag < c_LTH_V) begin
                                    if (w_lcnt_inc == c_LCN_V) begin
                                        w_state_nx = S_SLOW;
                                        w_lcnt_nx  = '0;
                                    end else begin
                                        w_lcnt_nx = w_lcnt_inc;
                                    end
                                end else begin
                                    w_lcnt_nx = '0;
                                end
                            end else if (w_mag < c_UTH_V) begin
                                w_fof_nx = sat24(w_sum_s);
                            end else begin
                                // Large error while tracking: fall back to coarse.
                                w_state_nx = S_FAST;
                                w_lcnt_nx  = '0;
                            end
                        end else begin
                            w_lcnt_nx = '0;
                            if (w_lsc_inc == c_LOS_V) begin
                                w_state_nx = S_HOLD;
                                w_lsc_nx   = '0;
                                w_hcnt_nx  = '0;
                            end else begin
                                w_lsc_nx = w_lsc_inc;
                            end
                        end
                    end
                end
                S_HOLD: begin
                    if (fmv) begin
                        if (fcd) begin
                            // Carrier back: resume coarse search, no correction yet.
                            w_state_nx = S_FAST;
                            w_lcnt_nx  = '0;
                            w_lsc_nx   = '0;
                            w_hcnt_nx  = '0;
                        end else if (w_hcnt_inc == c_HTO_V) begin
                            w_state_nx = S_FAST;
                            w_fof_nx   = '0;
                            w_lcnt_nx  = '0;
                            w_lsc_nx   = '0;
                            w_hcnt_nx  = '0;
                        end else begin
                            w_hcnt_nx = w_hcnt_inc;
                        end
                    end
                end
                default: begin
                    w_state_nx = S_IDLE;
                    w_fof_nx   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_fof   <= '0;
            r_nfl   <= '0;
            r_sfs   <= 1'b0;
            r_lck   <= 1'b0;
            r_upd   <= 1'b0;
            r_lcnt  <= '0;
            r_lsc   <= '0;
            r_hcnt  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_fof   <= w_fof_nx;
            r_nfl   <= w_nfl_nx;
            r_sfs   <= (w_state_nx == S_SLOW);
            r_lck   <= (w_state_nx == S_SLOW);
            r_upd   <= (w_fof_nx != r_fof);
            r_lcnt  <= w_lcnt_nx;
            r_lsc   <= w_lsc_nx;
            r_hcnt  <= w_hcnt_nx;
        end
    end

    assign nfl = r_nfl;
    assign sfs = r_sfs;
    assign lck = r_lck;
    assign fof = r_fof;
    assign upd = r_upd;

endmodule
`default_nettype wire

// File: tb/tb_fsyn_ctl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fsyn_ctl
// Description : Self-checking bench for fsyn_ctl. Each driven cycle pushes
//               its expected outputs to a queue; a negedge monitor pops and
//               compares them against the DUT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fsyn_ctl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [15:0] thr = '0;
    logic        fmv = 1'b0;
    logic [15:0] avgfrq = '0;
    logic        fcd = 1'b0;
    logic [15:0] nfl;
    logic        sfs;
    logic [23:0] fof;
    logic        upd;
    logic        lck;

    fsyn_ctl dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .thr    (thr),
        .fmv    (fmv),
        .avgfrq (avgfrq),
        .fcd    (fcd),
        .nfl    (nfl),
        .sfs    (sfs),
        .fof    (fof),
        .upd    (upd),
        .lck    (lck)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] fof;
        logic        sfs;
        logic        lck;
        logic        upd;
        logic [15:0] nfl;
    } exp_t;

    typedef struct {
        logic        fc;
        logic [15:0] a;
        logic [23:0] fof;
        logic        sfs;
    } vec_t;

    exp_t        q[$];
    exp_t        m_e;
    int          total = 0;
    int          bad = 0;

    logic        g_en = 1'b0;
    logic [15:0] g_thr = '0;
    logic [23:0] e_fof = '0;
    logic [15:0] e_nfl = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            m_e = q.pop_front();
            chk("fof", {8'd0, fof}, {8'd0, m_e.fof});
            chk("sfs", {31'd0, sfs}, {31'd0, m_e.sfs});
            chk("lck", {31'd0, lck}, {31'd0, m_e.lck});
            chk("upd", {31'd0, upd}, {31'd0, m_e.upd});
            chk("nfl", {16'd0, nfl}, {16'd0, m_e.nfl});
        end
    end

    function automatic logic [23:0] f24(input int v);
        return v[23:0];
    endfunction

    // One clock of stimulus with the outputs expected after its rising edge.
    task automatic step(input logic r, input logic e, input logic m, input logic fc,
                        input logic [15:0] a, input logic [23:0] nf, input logic ns);
        exp_t x;
        @(negedge clk);
        #1;
        rst    = r;
        en     = e;
        fmv    = m;
        fcd    = fc;
        avgfrq = a;
        thr    = g_thr;
        x.fof  = nf;
        x.sfs  = ns;
        x.lck  = ns;
        x.upd  = r ? 1'b0 : (nf != e_fof);
        x.nfl  = e_nfl;
        q.push_back(x);
        e_fof  = nf;
    endtask

    // One measurement strobe followed by one quiet cycle.
    task automatic strobe(input logic fc, input logic [15:0] a,
                          input logic [23:0] nf, input logic ns);
        step(1'b0, g_en, 1'b1, fc, a, nf, ns);
        step(1'b0, g_en, 1'b0, 1'b0, a, nf, ns);
    endtask

    vec_t tbl[6];

    initial begin
        int v;
        tbl[0] = '{1'b1, 16'd1024, f24(-256),  1'b0};
        tbl[1] = '{1'b1, 16'd1024, f24(-512),  1'b0};
        tbl[2] = '{1'b1, 16'd1024, f24(-768),  1'b0};
        tbl[3] = '{1'b1, 16'd1024, f24(-1024), 1'b0};
        tbl[4] = '{1'b1, 16'd2047, f24(-432),  1'b1};
        tbl[5] = '{1'b1, 16'hF800, f24(-432),  1'b0};

        // Reset, then strobes while disabled must do nothing.
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 24'd0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 24'd0, 1'b0);
        for (int i = 0; i < 10; i++) strobe(1'b1, 16'd1000, 24'd0, 1'b0);

        // Enable: a strobe on the IDLE->FAST edge is ignored; thr latched.
        g_en = 1'b1; g_thr = 16'd300; e_nfl = 16'd300;
        step(1'b0, 1'b1, 1'b1, 1'b1, 16'd1000, 24'd0, 1'b0);
        g_thr = 16'd777;
        for (int i = 0; i < 4; i++) strobe(tbl[i].fc, tbl[i].a, tbl[i].fof, tbl[i].sfs);

        // Disable clears a nonzero offset (with upd), re-enable latches new thr.
        g_en = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 24'd0, 1'b0);
        g_en = 1'b1; e_nfl = 16'd777;
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 24'd0, 1'b0);

        // Coarse lock after 16 qualifying strobes, then a fine step.
        for (int i = 1; i <= 16; i++) strobe(1'b1, 16'd100, f24(-25 * i), (i == 16));
        strobe(1'b1, 16'd100, f24(-401), 1'b1);

        // UTH boundary: 2047 tracks (+31 step), |-2048| drops back to FAST.
        for (int i = 4; i < 6; i++) strobe(tbl[i].fc, tbl[i].a, tbl[i].fof, tbl[i].sfs);
        for (int i = 1; i <= 16; i++) strobe(1'b1, 16'hFFF8, f24(-432 + 2 * i), (i == 16));

        // Floor behaviour of the fine shift: -5>>>6 = -1, 5>>>6 = 0.
        strobe(1'b1, 16'hFFFB, f24(-399), 1'b1);
        strobe(1'b1, 16'd5,    f24(-399), 1'b1);

        // Seven losses then a detect resets the loss count.
        for (int i = 0; i < 7; i++) strobe(1'b0, 16'd0, f24(-399), 1'b1);
        strobe(1'b1, 16'd0, f24(-399), 1'b1);
        for (int i = 1; i <= 8; i++) strobe(1'b0, 16'd0, f24(-399), (i < 8));

        // HOLD timeout clears the offset and resumes FAST.
        for (int i = 1; i <= 256; i++) strobe(1'b0, 16'd0, (i == 256) ? 24'd0 : f24(-399), 1'b0);
        strobe(1'b1, 16'd1024, f24(-256), 1'b0);

        // Carrier returns on the 100th hold strobe: no correction on it.
        for (int i = 0; i < 8; i++)  strobe(1'b0, 16'd0, f24(-256), 1'b0);
        for (int i = 0; i < 99; i++) strobe(1'b0, 16'd0, f24(-256), 1'b0);
        strobe(1'b1, 16'd1024, f24(-256), 1'b0);
        strobe(1'b1, 16'd1024, f24(-512), 1'b0);

        // Positive saturation.
        g_en = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 24'd0, 1'b0);
        g_en = 1'b1; g_thr = 16'd555; e_nfl = 16'd555;
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 24'd0, 1'b0);
        for (int i = 1; i <= 1100; i++) begin
            v = 8192 * i;
            if (v > 8388607) v = 8388607;
            strobe(1'b1, 16'h8000, f24(v), 1'b0);
        end

        // en=0 together with a strobe: IDLE, offset cleared, no correction.
        g_en = 1'b0;
        step(1'b0, 1'b0, 1'b1, 1'b1, 16'h8000, 24'd0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 24'd0, 1'b0);

        // Reset mid-operation overrides en and fmv.
        g_en = 1'b1;
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 24'd0, 1'b0);
        strobe(1'b1, 16'd1024, f24(-256), 1'b0);
        e_nfl = 16'd0;
        step(1'b1, 1'b1, 1'b1, 1'b1, 16'd1024, 24'd0, 1'b0);
        g_en = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 24'd0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 24'd0, 1'b0);

        @(negedge clk);
        @(negedge clk);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
